// File: rtl/ctrl_stage_pipe_pkg.sv
// ctrl_stage_pipe_pkg: decoder constants and per-stage control bundle types
package ctrl_stage_pipe_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_JAL  = 2'd2;
    localparam logic [1:0] NPC_JALR = 2'd3;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC4 = 2'd2;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd3;

    typedef struct packed {
        logic       valid;
        logic [1:0] npcop;
        logic [3:0] aluop;
        logic       asel;
        logic       bsel;
        logic       wen;
        logic       rfwr;
        logic [1:0] wdsel;
    } ex_ctrl_t;

    typedef struct packed {
        logic       valid;
        logic       wen;
        logic       rfwr;
        logic [1:0] wdsel;
    } mem_ctrl_t;

    typedef struct packed {
        logic       valid;
        logic       rfwr;
        logic [1:0] wdsel;
    } wb_ctrl_t;

    localparam ex_ctrl_t  EX_BUBBLE  = '0;
    localparam mem_ctrl_t MEM_BUBBLE = '0;
    localparam wb_ctrl_t  WB_BUBBLE  = '0;

    function automatic logic [1:0] wdsel_of(input logic [6:0] op);
        return op == OP_LOAD ? WD_MEM : (op == OP_JAL || op == OP_JALR) ? WD_PC4 : WD_ALU;
    endfunction
endpackage

// File: rtl/ctrl_pipe_reg.sv
// ctrl_pipe_reg: stage register with hold, bubble insertion and load
module ctrl_pipe_reg #(
    parameter int W = 8,
    parameter logic [W-1:0] BUBBLE = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         bubble,
    input  logic         hold,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    // hold beats bubble, bubble beats load
    always_ff @(posedge clk)
        if (!rst_n) q <= '0;
        else if (!hold) q <= bubble ? BUBBLE : load ? d : q;
endmodule

// File: rtl/ctrl_stage_pipe.sv
// ctrl_stage_pipe: ID/EX, EX/MEM, MEM/WB control pipeline with hazard handling and counters
module ctrl_stage_pipe
    import ctrl_stage_pipe_pkg::*;
#(
    parameter int RD_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [1:0]       id_npcop,
    input  logic             id_wen,
    input  logic [3:0]       id_aluop,
    input  logic             id_asel,
    input  logic             id_bsel,
    input  logic [2:0]       id_extop,
    input  logic             id_rfwr,
    input  logic [1:0]       id_wdsel,
    input  logic [RD_W-1:0]  id_rd,
    input  logic             stall,
    input  logic             flush,
    input  logic             hold,
    output logic             ex_valid,
    output logic [1:0]       ex_npcop,
    output logic [3:0]       ex_aluop,
    output logic             ex_asel,
    output logic             ex_bsel,
    output logic [RD_W-1:0]  ex_rd,
    output logic             mem_valid,
    output logic             mem_wen,
    output logic             mem_rfwr,
    output logic [1:0]       mem_wdsel,
    output logic [RD_W-1:0]  mem_rd,
    output logic             wb_valid,
    output logic             wb_rfwr,
    output logic [1:0]       wb_wdsel,
    output logic [RD_W-1:0]  wb_rd,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);
    ex_ctrl_t  id_ctrl, ex_q;
    mem_ctrl_t mem_d, mem_q;
    wb_ctrl_t  wb_d, wb_q;
    logic      unused_extop;

    assign unused_extop = ^id_extop;
    assign id_ctrl = '{valid: 1'b1, npcop: id_npcop, aluop: id_aluop, asel: id_asel,
                       bsel: id_bsel, wen: id_wen, rfwr: id_rfwr, wdsel: id_wdsel};
    assign mem_d = '{valid: ex_q.valid, wen: ex_q.wen, rfwr: ex_q.rfwr, wdsel: ex_q.wdsel};
    assign wb_d  = '{valid: mem_q.valid, rfwr: mem_q.rfwr, wdsel: mem_q.wdsel};

    ctrl_pipe_reg #(.W($bits(ex_ctrl_t) + RD_W), .BUBBLE({EX_BUBBLE, {RD_W{1'b0}}})) u_idex (
        .clk, .rst_n, .load(1'b1), .bubble(flush | stall | !id_valid), .hold,
        .d({id_ctrl, id_rd}), .q({ex_q, ex_rd})
    );

    ctrl_pipe_reg #(.W($bits(mem_ctrl_t) + RD_W), .BUBBLE({MEM_BUBBLE, {RD_W{1'b0}}})) u_exmem (
        .clk, .rst_n, .load(1'b1), .bubble(1'b0), .hold,
        .d({mem_d, ex_rd}), .q({mem_q, mem_rd})
    );

    ctrl_pipe_reg #(.W($bits(wb_ctrl_t) + RD_W), .BUBBLE({WB_BUBBLE, {RD_W{1'b0}}})) u_memwb (
        .clk, .rst_n, .load(1'b1), .bubble(1'b0), .hold,
        .d({wb_d, mem_rd}), .q({wb_q, wb_rd})
    );

    assign ex_valid  = ex_q.valid;
    assign ex_npcop  = ex_q.valid ? ex_q.npcop : 2'd0;
    assign ex_aluop  = ex_q.aluop;
    assign ex_asel   = ex_q.asel;
    assign ex_bsel   = ex_q.bsel;
    assign mem_valid = mem_q.valid;
    assign mem_wen   = mem_q.valid & mem_q.wen;
    assign mem_rfwr  = mem_q.valid & mem_q.rfwr & (|mem_rd);
    assign mem_wdsel = mem_q.wdsel;
    assign wb_valid  = wb_q.valid;
    assign wb_rfwr   = wb_q.valid & wb_q.rfwr & (|wb_rd);
    assign wb_wdsel  = wb_q.wdsel;

    // retire and bubble counters freeze on hold and wrap freely; one bubble even if flush and stall coincide
    always_ff @(posedge clk)
        if (!rst_n) begin
            retire_cnt <= '0;
            bubble_cnt <= '0;
        end else if (!hold) begin
            retire_cnt <= retire_cnt + CNT_W'(wb_valid);
            bubble_cnt <= bubble_cnt + CNT_W'(flush | stall);
        end
endmodule
